spi_mem_bridge: RTL and testbench

//  Parametrised SPI-slave-to-memory/control bridge; next generation of the SPI command layer.

---
 rtl/spi_mem_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_mem_bridge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: SPI mode-3 slave (MSB first) oversampled in the CLK domain,
// decoding opcode/argument/data words into register-memory bursts, a channel
// enable vector and sticky error flags.
module spi_mem_bridge #(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 4,
  parameter int unsigned N_CH      = 1,
  parameter int unsigned BURST_LEN = 5,
  parameter bit          WRAP      = 1'b1,
  parameter logic [7:0]  REV_ID    = 8'h0A
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            CCLK,
  input  logic            SCSN,
  input  logic            SI,
  output logic            SO,
  output logic            MEM_WR,
  output logic            MEM_RD,
  output logic [AW-1:0]   MEM_ADDR,
  output logic [DW-1:0]   MEM_WDATA,
  input  logic [DW-1:0]   MEM_RDATA,
  output logic [N_CH-1:0] ENABLE,
  input  logic            RESETEN,
  output logic            BUSY,
  output logic [1:0]      ERR
);
  localparam int unsigned BW = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] OP_EN_SET  = 8'h01;
  localparam logic [7:0] OP_EN_CLR  = 8'h02;
  localparam logic [7:0] OP_MEM_WR  = 8'h03;
  localparam logic [7:0] OP_MEM_RD  = 8'h04;
  localparam logic [7:0] OP_REV_ID  = 8'h05;
  localparam logic [7:0] OP_STATUS  = 8'h06;
  localparam logic [7:0] OP_CLR_ERR = 8'h07;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARG, S_DATA, S_DRAIN} state_t;
  state_t r_state, w_next;

  logic [2:0]      r_cclk_s, r_scsn_s;
  logic [1:0]      r_si_s;
  logic            r_armed;
  logic            w_cs, w_cclk_rise, w_cclk_fall, w_scsn_fall;
  logic [BW-1:0]   r_bitcnt;
  logic [DW-2:0]   r_rx;
  logic [DW-1:0]   w_rx_word, r_word, r_tx;
  logic            w_word_done, r_wv, r_so, r_mem_rd, r_rd_d1;
  logic [7:0]      r_op;
  logic [AW-1:0]   r_addr, r_start, w_wrap_end, w_addr_next;
  logic [CW-1:0]   r_cnt;
  logic [N_CH-1:0] r_en;
  logic [1:0]      r_err;
  logic            w_mem_wr, w_rd_req, w_tx_load, w_addr_start, w_addr_adv, w_cnt_inc;
  logic            w_err_clr, w_en_set, w_en_clr, w_op_load;
  logic [1:0]      w_err_set;
  logic [DW-1:0]   w_tx_val;

  // Synchronise SPI inputs. The SCSN chain resets to "selected" and r_armed only
  // rises once a genuine high has been seen, so a SCSN held low across RESET
  // cannot fake a falling edge: the host must deselect and reselect.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cclk_s <= '1;
      r_scsn_s <= '0;
      r_si_s   <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_cclk_s <= {r_cclk_s[1:0], CCLK};
      r_scsn_s <= {r_scsn_s[1:0], SCSN};
      r_si_s   <= {r_si_s[0], SI};
      if (r_scsn_s[1]) r_armed <= 1'b1;
    end
  end

  assign w_cs        = r_armed & ~r_scsn_s[1];
  assign w_scsn_fall = r_armed & r_scsn_s[2] & ~r_scsn_s[1];
  assign w_cclk_rise = r_cclk_s[1] & ~r_cclk_s[2];
  assign w_cclk_fall = ~r_cclk_s[1] & r_cclk_s[2];
  assign w_rx_word   = {r_rx, r_si_s[1]};
  assign w_word_done = w_cs && (r_state != S_IDLE) && w_cclk_rise && (r_bitcnt == BW'(DW - 1));

  // Receive shifter: sample SI on CCLK rise, emit word_valid after DW bits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bitcnt <= '0;
      r_rx     <= '0;
      r_wv     <= 1'b0;
      r_word   <= '0;
    end else begin
      r_wv <= w_word_done;
      if (w_word_done) r_word <= w_rx_word;
      if (!w_cs || r_state == S_IDLE) begin
        r_bitcnt <= '0;
      end else if (w_cclk_rise) begin
        r_rx     <= w_rx_word[DW-2:0];
        r_bitcnt <= w_word_done ? '0 : r_bitcnt + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state decode; deselect returns to IDLE from anywhere.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_scsn_fall) w_next = S_CMD;
      S_CMD:  if (r_wv) w_next = (r_word[7:0] >= OP_EN_SET && r_word[7:0] <= OP_MEM_RD) ? S_ARG : S_DRAIN;
      S_ARG:  if (r_wv) w_next = (r_op == OP_MEM_WR || r_op == OP_MEM_RD) ? S_DATA : S_DRAIN;
      default: ;
    endcase
    if (r_state != S_IDLE && !w_cs) w_next = S_IDLE;
  end

  // FSM output decode: per-word actions taken on word_valid.
  always_comb begin
    w_mem_wr     = 1'b0;
    w_rd_req     = 1'b0;
    w_tx_load    = 1'b0;
    w_tx_val     = '1;
    w_addr_start = 1'b0;
    w_addr_adv   = 1'b0;
    w_cnt_inc    = 1'b0;
    w_err_set    = 2'b00;
    w_err_clr    = 1'b0;
    w_en_set     = 1'b0;
    w_en_clr     = 1'b0;
    w_op_load    = 1'b0;
    if (r_wv) begin
      w_tx_load = 1'b1;
      case (r_state)
        S_CMD: begin
          w_op_load = 1'b1;
          case (r_word[7:0])
            OP_REV_ID:  w_tx_val = DW'(REV_ID);
            OP_STATUS:  w_tx_val = DW'({r_err, r_en});
            OP_CLR_ERR: w_err_clr = 1'b1;
            OP_EN_SET, OP_EN_CLR, OP_MEM_WR, OP_MEM_RD: ;
            default:    w_err_set[0] = 1'b1;
          endcase
        end
        S_ARG: begin
          case (r_op)
            OP_EN_SET: w_en_set = 1'b1;
            OP_EN_CLR: w_en_clr = 1'b1;
            OP_MEM_WR: w_addr_start = 1'b1;
            OP_MEM_RD: begin
              w_addr_start = 1'b1;
              w_rd_req     = 1'b1;
            end
            default: ;
          endcase
        end
        S_DATA: begin
          // Reads were prefetched one word ahead, so the last in-burst word
          // requests nothing further.
          if (r_cnt < CW'(BURST_LEN)) begin
            w_cnt_inc = 1'b1;
            if (r_op == OP_MEM_WR) begin
              w_mem_wr   = 1'b1;
              w_addr_adv = 1'b1;
            end else if ((r_cnt + 1'b1) < CW'(BURST_LEN)) begin
              w_addr_adv = 1'b1;
              w_rd_req   = 1'b1;
            end
          end else begin
            w_err_set[1] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_wrap_end  = r_start + AW'(BURST_LEN - 1);
  assign w_addr_next = (WRAP && (r_addr == w_wrap_end)) ? r_start : r_addr + 1'b1;

  // Datapath: address/burst tracking, enables, error flags and transmit shifter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_op     <= '0;
      r_addr   <= '0;
      r_start  <= '0;
      r_cnt    <= '0;
      r_mem_rd <= 1'b0;
      r_rd_d1  <= 1'b0;
      r_en     <= '0;
      r_err    <= '0;
      r_tx     <= '1;
      r_so     <= 1'b1;
    end else begin
      r_mem_rd <= w_rd_req;
      r_rd_d1  <= r_mem_rd;
      if (w_op_load) r_op <= r_word[7:0];
      if (w_addr_start) begin
        r_addr  <= r_word[AW-1:0];
        r_start <= r_word[AW-1:0];
        r_cnt   <= '0;
      end else if (w_addr_adv) begin
        r_addr <= w_addr_next;
      end
      if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_err_clr) r_err <= '0;
      else           r_err <= r_err | w_err_set;
      if (RESETEN)       r_en <= '0;
      else if (w_en_set) r_en <= r_en | r_word[N_CH-1:0];
      else if (w_en_clr) r_en <= r_en & ~r_word[N_CH-1:0];
      if (!w_cs) begin
        r_so <= 1'b1;
        r_tx <= '1;
      end else if (w_cclk_fall) begin
        r_so <= r_tx[DW-1];
        r_tx <= {r_tx[DW-2:0], 1'b1};
      end
      if (w_scsn_fall)    r_tx <= DW'(REV_ID);
      else if (w_tx_load) r_tx <= w_tx_val;
      if (r_rd_d1) r_tx <= MEM_RDATA;
    end
  end

  assign SO        = r_so;
  assign MEM_WR    = w_mem_wr;
  assign MEM_RD    = r_mem_rd;
  assign MEM_ADDR  = r_addr;
  assign MEM_WDATA = r_word;
  assign ENABLE    = r_en;
  assign ERR       = r_err;
  assign BUSY      = w_cs;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: directed plus random SPI transactions against a
// transaction-level reference model of the bridge.
module tb_spi_mem_bridge;
  localparam int HP = 60;

  logic       CLK = 1'b0;
  logic       RESET, CCLK, SCSN, SI, RESETEN;
  logic       SO, MEM_WR, MEM_RD, BUSY;
  logic [3:0] MEM_ADDR, ENABLE;
  logic [7:0] MEM_WDATA;
  logic [7:0] MEM_RDATA;
  logic [1:0] ERR;

  spi_mem_bridge #(.DW(8), .AW(4), .N_CH(4), .BURST_LEN(5), .WRAP(1'b1), .REV_ID(8'h0A)) dut (
    .CLK(CLK), .RESET(RESET), .CCLK(CCLK), .SCSN(SCSN), .SI(SI), .SO(SO),
    .MEM_WR(MEM_WR), .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .ENABLE(ENABLE), .RESETEN(RESETEN), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) ^ 8'hA5);
  endfunction

  // Memory attached to the bridge, plus a log of write strobes and read count.
  logic [7:0]  mem [16];
  logic [11:0] wr_log[$];
  int          rd_cnt = 0;
  always @(negedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) mem[i] = init_val(i);
      MEM_RDATA = '0;
    end else begin
      if (MEM_WR) begin
        mem[MEM_ADDR] = MEM_WDATA;
        wr_log.push_back({MEM_ADDR, MEM_WDATA});
      end
      if (MEM_RD) begin
        MEM_RDATA = mem[MEM_ADDR];
        rd_cnt++;
      end
    end
  end

  int n_chk = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Host-side SPI master, mode 3: drive SI after the falling edge, sample SO at the rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int b = 7; b > 7 - nb; b--) begin
      CCLK = 1'b0; SI = tx[b]; #HP;
      CCLK = 1'b1; rx[b] = SO; #HP;
    end
  endtask

  logic [7:0] tx_buf[16];
  logic [7:0] rx_buf[16];
  task automatic spi_txn(input int n, input int abort_bits);
    logic [7:0] junk;
    SCSN = 1'b0; #HP;
    for (int i = 0; i < n; i++) spi_bits(tx_buf[i], 8, rx_buf[i]);
    if (abort_bits > 0) spi_bits(8'h5A, abort_bits, junk);
    SCSN = 1'b1; #(2 * HP);
  endtask

  // Reference model: outcome of a whole transaction from the command rules.
  logic [7:0]  ref_mem[16];
  logic [3:0]  m_en;
  logic [1:0]  m_err;
  logic [7:0]  exp_so[16];
  logic [11:0] exp_wr[$];
  int          exp_rd;
  function automatic void model(input int n);
    logic [7:0] op;
    int start, a;
    exp_wr.delete();
    exp_rd = 0;
    for (int i = 0; i < 16; i++) exp_so[i] = 8'hFF;
    exp_so[0] = 8'h0A;
    if (n < 1) return;
    op = tx_buf[0];
    case (op)
      8'h01: if (n >= 2) m_en = m_en | tx_buf[1][3:0];
      8'h02: if (n >= 2) m_en = m_en & ~tx_buf[1][3:0];
      8'h05: exp_so[1] = 8'h0A;
      8'h06: exp_so[1] = {2'b00, m_err, m_en};
      8'h07: m_err = 2'b00;
      8'h03, 8'h04: begin
        if (n >= 2) begin
          start = int'(tx_buf[1][3:0]);
          if (op == 8'h04) exp_rd = 1 + ((n - 2 < 4) ? n - 2 : 4);
          for (int k = 1; k <= n - 2; k++) begin
            if (k > 5) begin
              m_err[1] = 1'b1;
            end else begin
              a = (start + k - 1) % 16;
              if (op == 8'h03) begin
                exp_wr.push_back({a[3:0], tx_buf[k + 1]});
                ref_mem[a] = tx_buf[k + 1];
              end else begin
                exp_so[k + 1] = ref_mem[a];
              end
            end
          end
        end
      end
      default: m_err[0] = 1'b1;
    endcase
  endfunction

  task automatic do_txn(input int n, input int abort_bits, input bit rsten, input string tag);
    int wr_base, rd_base;
    wr_base = wr_log.size();
    rd_base = rd_cnt;
    model(n);
    if (rsten) m_en = '0;
    RESETEN = rsten;
    spi_txn(n, abort_bits);
    RESETEN = 1'b0;
    for (int i = 0; i < n; i++) chk($sformatf("%s so[%0d]", tag, i), 32'(rx_buf[i]), 32'(exp_so[i]));
    chk({tag, " nwr"}, wr_log.size() - wr_base, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && wr_base + i < wr_log.size(); i++)
      chk($sformatf("%s wr[%0d]", tag, i), 32'(wr_log[wr_base + i]), 32'(exp_wr[i]));
    chk({tag, " nrd"}, rd_cnt - rd_base, exp_rd);
    chk({tag, " enable"}, 32'(ENABLE), 32'(m_en));
    chk({tag, " err"}, 32'(ERR), 32'(m_err));
    chk({tag, " busy"}, 32'(BUSY), 32'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " SO"}, 32'(SO), 32'(1));
    chk({tag, " MEM_WR"}, 32'(MEM_WR), 32'(0));
    chk({tag, " MEM_RD"}, 32'(MEM_RD), 32'(0));
    chk({tag, " MEM_ADDR"}, 32'(MEM_ADDR), 32'(0));
    chk({tag, " MEM_WDATA"}, 32'(MEM_WDATA), 32'(0));
    chk({tag, " ENABLE"}, 32'(ENABLE), 32'(0));
    chk({tag, " BUSY"}, 32'(BUSY), 32'(0));
    chk({tag, " ERR"}, 32'(ERR), 32'(0));
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    m_en = '0;
    m_err = '0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] junk;
    int n, ab, r;
    CCLK = 1'b1; SCSN = 1'b1; SI = 1'b0; RESETEN = 1'b0;
    do_reset();
    check_reset_vals("T1 reset");
    RESET = 1'b0; #(2 * HP);

    tx_buf[0] = 8'h05; tx_buf[1] = 8'h00;
    do_txn(2, 0, 1'b0, "T1 rev");

    tx_buf[0] = 8'h03; tx_buf[1] = 8'h02; tx_buf[2] = 8'hA1; tx_buf[3] = 8'hB2; tx_buf[4] = 8'hC3;
    do_txn(5, 0, 1'b0, "T2 wr");

    tx_buf[0] = 8'h04; tx_buf[1] = 8'h03;
    for (int i = 2; i < 8; i++) tx_buf[i] = 8'($urandom);
    do_txn(8, 0, 1'b0, "T3 rd");
    tx_buf[0] = 8'h07;
    do_txn(1, 0, 1'b0, "T3 clr");

    tx_buf[0] = 8'h01; tx_buf[1] = 8'h05;
    do_txn(2, 0, 1'b0, "T4 set");
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h01;
    do_txn(2, 0, 1'b0, "T4 clr");
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h0F;
    do_txn(2, 0, 1'b1, "T4 reseten");

    tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h11;
    do_txn(3, 3, 1'b0, "T5 abort");
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h00;
    do_txn(2, 0, 1'b0, "T5 idle");

    tx_buf[0] = 8'h01; tx_buf[1] = 8'h0A;
    do_txn(2, 0, 1'b0, "T6 en");
    tx_buf[0] = 8'h3F;
    do_txn(1, 0, 1'b0, "T6 bad");
    tx_buf[0] = 8'h06; tx_buf[1] = 8'h00;
    do_txn(2, 0, 1'b0, "T6 status");
    tx_buf[0] = 8'h07;
    do_txn(1, 0, 1'b0, "T6 clr");

    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      tx_buf[0] = (r < 7) ? 8'(r + 1) : 8'($urandom);
      for (int i = 1; i < 16; i++) tx_buf[i] = 8'($urandom);
      n  = $urandom_range(1, 9);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      do_txn(n, ab, 1'b0, $sformatf("R%0d op%02h", t, tx_buf[0]));
    end

    // Reset in the middle of a write burst with SCSN still asserted.
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h0C;
    do_txn(2, 0, 1'b0, "MR pre_en");
    tx_buf[0] = 8'hEE;
    do_txn(1, 0, 1'b0, "MR pre_err");
    SCSN = 1'b0; #HP;
    spi_bits(8'h03, 8, junk);
    spi_bits(8'h05, 4, junk);
    do_reset();
    check_reset_vals("MR reset");
    RESET = 1'b0; #(4 * HP);
    chk("MR busy_held_low", 32'(BUSY), 32'(0));
    chk("MR so_held_low", 32'(SO), 32'(1));
    SCSN = 1'b1; CCLK = 1'b1; #(2 * HP);
    tx_buf[0] = 8'h06; tx_buf[1] = 8'h00;
    do_txn(2, 0, 1'b0, "MR status");
    tx_buf[0] = 8'h04; tx_buf[1] = 8'h0E;
    for (int i = 2; i < 7; i++) tx_buf[i] = 8'($urandom);
    do_txn(7, 0, 1'b0, "MR rd_wrap16");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
